// File: rtl/vdp_pkg.sv
// Shared constants for the VDP CPU port: access codes, register indices and
// the port FSM encoding.
package vdp_pkg;
  localparam logic [1:0] VRAM_RD = 2'd0;
  localparam logic [1:0] VRAM_WR = 2'd1;
  localparam logic [1:0] REG_WR  = 2'd2;
  localparam logic [1:0] CRAM_WR = 2'd3;

  localparam int REG_MODE1    = 1;
  localparam int REG_NAME     = 2;
  localparam int REG_SAT      = 5;
  localparam int REG_SPG      = 6;
  localparam int REG_BACKDROP = 7;
  localparam int REG_HSCROLL  = 8;
  localparam int REG_VSCROLL  = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH_A = 2'd1,
    ST_FETCH_D = 2'd2
  } port_state_t;
endpackage

// File: rtl/vdp_cpu_port_if.sv
// CPU-side bus of the VDP: port select, one-cycle strobes, write and read data.
interface vdp_cpu_port_if;
  logic       cpu_sel;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;

  modport master (output cpu_sel, cpu_wr, cpu_rd, cpu_di, input cpu_do);
  modport slave  (input cpu_sel, cpu_wr, cpu_rd, cpu_di, output cpu_do);
endinterface

// File: rtl/vdp_regs.sv
// VDP register file with the field decode consumed by the display pipeline.
module vdp_regs
  import vdp_pkg::*;
#(
  parameter int NUM_REGS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  idx,
  input  logic [7:0]  wd,
  output logic [13:0] name_table_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pat_base,
  output logic [7:0]  hscroll,
  output logic [7:0]  vscroll,
  output logic [3:0]  backdrop,
  output logic        display_en
);
  logic [7:0] regs [NUM_REGS];
  logic [7:0] rv   [16];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (32'(idx) < NUM_REGS)) begin
      regs[idx] <= wd;
    end
  end

  // Unimplemented indices read as zero so the decode holds for small NUM_REGS.
  for (genvar g = 0; g < 16; g++) begin : g_rv
    if (g < NUM_REGS) begin : g_impl
      assign rv[g] = regs[g];
    end else begin : g_zero
      assign rv[g] = '0;
    end
  end

  assign name_table_addr  = {rv[REG_NAME][3:1], 11'b0};
  assign sprite_attr_addr = {rv[REG_SAT][6:1], 8'b0};
  assign sprite_pat_base  = {rv[REG_SPG][2], 13'b0};
  assign backdrop         = rv[REG_BACKDROP][3:0];
  assign hscroll          = rv[REG_HSCROLL];
  assign vscroll          = rv[REG_VSCROLL];
  assign display_en       = rv[REG_MODE1][6];
endmodule

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: two-byte control latch, VRAM read-ahead buffer, VRAM/CRAM
// writes, status read and register writes.
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int NUM_REGS = 11,
  parameter int VRAM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  vdp_cpu_port_if.slave      cpu,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_a,
  output logic [7:0]         vram_wd,
  input  logic [7:0]         vram_rd,
  output logic               cram_we,
  output logic [4:0]         cram_a,
  output logic [15:0]        cram_wd,
  input  logic [2:0]         status_in,
  output logic               status_rd,
  output logic [13:0]        name_table_addr,
  output logic [13:0]        sprite_attr_addr,
  output logic [13:0]        sprite_pat_base,
  output logic [7:0]         hscroll,
  output logic [7:0]         vscroll,
  output logic [3:0]         backdrop,
  output logic               display_en,
  output logic               busy,
  output logic               overrun
);
  port_state_t        state, state_nx;
  logic [VRAM_AW-1:0] addr, addr_nx, wr_a, wr_a_nx;
  logic [1:0]         code, code_nx;
  logic               latch, latch_nx;
  logic [7:0]         buffer, buf_nx, cram_lo, cram_lo_nx, do_q, do_nx, vram_wd_nx;
  logic               vram_we_nx, cram_we_nx, status_rd_nx, overrun_nx;
  logic [4:0]         cram_a_nx;
  logic [15:0]        cram_wd_nx;
  logic               reg_we;
  logic [3:0]         reg_idx;
  logic [7:0]         reg_wd;
  logic               strobe;

  assign strobe = cpu.cpu_wr | cpu.cpu_rd;

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    code_nx      = code;
    latch_nx     = latch;
    buf_nx       = buffer;
    cram_lo_nx   = cram_lo;
    do_nx        = do_q;
    vram_we_nx   = 1'b0;
    wr_a_nx      = wr_a;
    vram_wd_nx   = vram_wd;
    cram_we_nx   = 1'b0;
    cram_a_nx    = cram_a;
    cram_wd_nx   = cram_wd;
    status_rd_nx = 1'b0;
    overrun_nx   = overrun;
    reg_we       = 1'b0;
    reg_idx      = cpu.cpu_di[3:0];
    reg_wd       = addr[7:0];
    case (state)
      ST_IDLE: begin
        // A simultaneous write and read is treated as the write alone.
        if (cpu.cpu_wr) begin
          if (cpu.cpu_sel) begin
            if (!latch) begin
              addr_nx[7:0] = cpu.cpu_di;
              latch_nx     = 1'b1;
            end else begin
              addr_nx[VRAM_AW-1:8] = cpu.cpu_di[VRAM_AW-9:0];
              code_nx              = cpu.cpu_di[7:6];
              latch_nx             = 1'b0;
              if (cpu.cpu_di[7:6] == VRAM_RD) state_nx = ST_FETCH_A;
              if (cpu.cpu_di[7:6] == REG_WR)  reg_we   = 1'b1;
            end
          end else begin
            latch_nx = 1'b0;
            buf_nx   = cpu.cpu_di;
            addr_nx  = addr + VRAM_AW'(1);
            if (code == CRAM_WR) begin
              // CRAM words are assembled from an even/odd byte pair.
              if (!addr[0]) begin
                cram_lo_nx = cpu.cpu_di;
              end else begin
                cram_we_nx = 1'b1;
                cram_a_nx  = addr[5:1];
                cram_wd_nx = {cpu.cpu_di, cram_lo};
              end
            end else begin
              vram_we_nx = 1'b1;
              wr_a_nx    = addr;
              vram_wd_nx = cpu.cpu_di;
            end
          end
        end else if (cpu.cpu_rd) begin
          latch_nx = 1'b0;
          if (cpu.cpu_sel) begin
            do_nx        = {status_in, 5'b0};
            status_rd_nx = 1'b1;
          end else begin
            do_nx    = buffer;
            state_nx = ST_FETCH_A;
          end
        end
      end
      ST_FETCH_A: begin
        state_nx = ST_FETCH_D;
        if (strobe) overrun_nx = 1'b1;
      end
      ST_FETCH_D: begin
        state_nx = ST_IDLE;
        buf_nx   = vram_rd;
        addr_nx  = addr + VRAM_AW'(1);
        if (strobe) overrun_nx = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      code      <= '0;
      latch     <= 1'b0;
      buffer    <= '0;
      cram_lo   <= '0;
      do_q      <= '0;
      vram_we   <= 1'b0;
      wr_a      <= '0;
      vram_wd   <= '0;
      cram_we   <= 1'b0;
      cram_a    <= '0;
      cram_wd   <= '0;
      status_rd <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      code      <= code_nx;
      latch     <= latch_nx;
      buffer    <= buf_nx;
      cram_lo   <= cram_lo_nx;
      do_q      <= do_nx;
      vram_we   <= vram_we_nx;
      wr_a      <= wr_a_nx;
      vram_wd   <= vram_wd_nx;
      cram_we   <= cram_we_nx;
      cram_a    <= cram_a_nx;
      cram_wd   <= cram_wd_nx;
      status_rd <= status_rd_nx;
      overrun   <= overrun_nx;
    end
  end

  // The fetch address is only presented while FETCH_A is outstanding.
  assign vram_a     = (state == ST_FETCH_A) ? addr : wr_a;
  assign busy       = (state != ST_IDLE);
  assign cpu.cpu_do = do_q;

  vdp_regs #(.NUM_REGS(NUM_REGS)) u_regs (
    .clk              (clk),
    .rst              (rst),
    .we               (reg_we),
    .idx              (reg_idx),
    .wd               (reg_wd),
    .name_table_addr  (name_table_addr),
    .sprite_attr_addr (sprite_attr_addr),
    .sprite_pat_base  (sprite_pat_base),
    .hscroll          (hscroll),
    .vscroll          (vscroll),
    .backdrop         (backdrop),
    .display_en       (display_en)
  );
endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: directed accesses push expected events,
// a monitor pops and compares whenever the DUT emits a write, status or read.
module tb_vdp_cpu_port;
  localparam int K_VW = 0, K_CW = 1, K_RD = 2, K_ST = 3;

  typedef struct {
    int          kind;
    logic [13:0] a;
    logic [15:0] d;
  } exp_t;

  logic        clk, rst;
  logic        vram_we, cram_we, status_rd, busy, overrun, display_en;
  logic [13:0] vram_a, name_table_addr, sprite_attr_addr, sprite_pat_base;
  logic [7:0]  vram_wd, vram_rd, hscroll, vscroll;
  logic [4:0]  cram_a;
  logic [15:0] cram_wd;
  logic [2:0]  status_in;
  logic [3:0]  backdrop;
  logic        rd_q;
  logic [7:0]  mem [16384];

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  vdp_cpu_port_if cpu_if ();

  vdp_cpu_port #(.NUM_REGS(11), .VRAM_AW(14)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu              (cpu_if),
    .vram_we          (vram_we),
    .vram_a           (vram_a),
    .vram_wd          (vram_wd),
    .vram_rd          (vram_rd),
    .cram_we          (cram_we),
    .cram_a           (cram_a),
    .cram_wd          (cram_wd),
    .status_in        (status_in),
    .status_rd        (status_rd),
    .name_table_addr  (name_table_addr),
    .sprite_attr_addr (sprite_attr_addr),
    .sprite_pat_base  (sprite_pat_base),
    .hscroll          (hscroll),
    .vscroll          (vscroll),
    .backdrop         (backdrop),
    .display_en       (display_en),
    .busy             (busy),
    .overrun          (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // VRAM with synchronous read, one cycle of latency.
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h1234] = 8'h11;
    mem[14'h1235] = 8'h22;
  end
  always @(posedge clk) begin
    if (vram_we) mem[vram_a] <= vram_wd;
    vram_rd <= mem[vram_a];
  end

  always @(posedge clk) rd_q <= rst & cpu_if.cpu_rd & ~cpu_if.cpu_wr & ~cpu_if.cpu_sel;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [13:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = k; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic mon(input int k, input logic [13:0] a, input logic [15:0] d, input string nm);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event a=%h d=%h, none required", nm, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.a != a || e.d != d) begin
        n_bad++;
        $display("FAIL %s: got kind=%0d a=%h d=%h required kind=%0d a=%h d=%h",
                 nm, k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (vram_we)   mon(K_VW, vram_a, {8'h00, vram_wd}, "vram_wr");
      if (cram_we)   mon(K_CW, {9'h000, cram_a}, cram_wd, "cram_wr");
      if (status_rd) mon(K_ST, 14'h0000, {8'h00, cpu_if.cpu_do}, "status_rd");
      if (rd_q)      mon(K_RD, 14'h0000, {8'h00, cpu_if.cpu_do}, "data_rd");
    end
  end

  task automatic acc(input logic sel, input logic wr, input logic rd, input logic [7:0] di);
    cpu_if.cpu_sel = sel;
    cpu_if.cpu_wr  = wr;
    cpu_if.cpu_rd  = rd;
    cpu_if.cpu_di  = di;
    @(posedge clk);
    #1;
    cpu_if.cpu_wr = 1'b0;
    cpu_if.cpu_rd = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] b0, input logic [7:0] b1);
    acc(1'b1, 1'b1, 1'b0, b0);
    acc(1'b1, 1'b1, 1'b0, b1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    status_in = 3'b101;
    cpu_if.cpu_sel = 1'b0;
    cpu_if.cpu_wr  = 1'b0;
    cpu_if.cpu_rd  = 1'b0;
    cpu_if.cpu_di  = 8'h00;
    cyc(3);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_overrun", {15'h0, overrun}, 16'h0);
    chk("rst_cpu_do", {8'h0, cpu_if.cpu_do}, 16'h0);
    chk("rst_strobes", {13'h0, vram_we, cram_we, status_rd}, 16'h0);
    chk("rst_name_table", {2'b0, name_table_addr}, 16'h0);
    rst = 1'b1;
    cyc(1);

    // Two VRAM writes then a third proving the address reached 0x0002.
    expect_ev(K_VW, 14'h0000, 16'h00AA);
    expect_ev(K_VW, 14'h0001, 16'h0055);
    expect_ev(K_VW, 14'h0002, 16'h0077);
    ctrl(8'h00, 8'h40);
    acc(1'b0, 1'b1, 1'b0, 8'hAA);
    acc(1'b0, 1'b1, 1'b0, 8'h55);
    acc(1'b0, 1'b1, 1'b0, 8'h77);

    // Register writes and field decode; index 12 is out of range.
    ctrl(8'h0E, 8'h82);
    cyc(1);
    chk("name_table", {2'b0, name_table_addr}, 16'h3800);
    ctrl(8'h40, 8'h81);
    ctrl(8'h7E, 8'h85);
    ctrl(8'h04, 8'h86);
    ctrl(8'hF5, 8'h87);
    ctrl(8'h12, 8'h88);
    ctrl(8'h34, 8'h89);
    ctrl(8'hFF, 8'h8C);
    cyc(1);
    chk("display_en", {15'h0, display_en}, 16'h1);
    chk("sprite_attr", {2'b0, sprite_attr_addr}, 16'h3F00);
    chk("sprite_pat", {2'b0, sprite_pat_base}, 16'h2000);
    chk("backdrop", {12'h0, backdrop}, 16'h0005);
    chk("hscroll", {8'h0, hscroll}, 16'h0012);
    chk("vscroll", {8'h0, vscroll}, 16'h0034);
    chk("name_table_kept", {2'b0, name_table_addr}, 16'h3800);

    // Read-ahead: busy for exactly two cycles, then buffered reads.
    ctrl(8'h34, 8'h12);
    chk("busy_fa", {15'h0, busy}, 16'h1);
    cyc(1);
    chk("busy_fd", {15'h0, busy}, 16'h1);
    cyc(1);
    chk("busy_done", {15'h0, busy}, 16'h0);
    expect_ev(K_RD, 14'h0000, 16'h0011);
    acc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(2);
    expect_ev(K_RD, 14'h0000, 16'h0022);
    acc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(2);

    // Address wrap; second write also raises rd, which must be ignored.
    expect_ev(K_VW, 14'h3FFF, 16'h0001);
    expect_ev(K_VW, 14'h0000, 16'h0002);
    ctrl(8'hFF, 8'h7F);
    acc(1'b0, 1'b1, 1'b0, 8'h01);
    acc(1'b0, 1'b1, 1'b1, 8'h02);
    chk("wr_rd_no_fetch", {15'h0, busy}, 16'h0);

    // CRAM byte pairing.
    expect_ev(K_CW, 14'h0002, 16'h0F3C);
    ctrl(8'h04, 8'hC0);
    acc(1'b0, 1'b1, 1'b0, 8'h3C);
    acc(1'b0, 1'b1, 1'b0, 8'h0F);
    cyc(1);

    // Status read clears the latch; a write follows at 0x0020.
    expect_ev(K_ST, 14'h0000, 16'h00A0);
    expect_ev(K_VW, 14'h0020, 16'h0099);
    acc(1'b1, 1'b1, 1'b0, 8'h10);
    acc(1'b1, 1'b0, 1'b1, 8'h00);
    ctrl(8'h20, 8'h40);
    acc(1'b0, 1'b1, 1'b0, 8'h99);
    cyc(1);

    // A write strobe during a fetch is dropped and sets overrun.
    chk("overrun_clear", {15'h0, overrun}, 16'h0);
    ctrl(8'h00, 8'h00);
    acc(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("overrun_set", {15'h0, overrun}, 16'h1);
    cyc(1);
    expect_ev(K_RD, 14'h0000, 16'h0002);
    acc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(3);
    chk("overrun_sticky", {15'h0, overrun}, 16'h1);

    // Reset mid-fetch aborts it and clears buffer and address.
    ctrl(8'h34, 8'h12);
    rst = 1'b0;
    #2;
    chk("abort_busy", {15'h0, busy}, 16'h0);
    chk("abort_overrun", {15'h0, overrun}, 16'h0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    expect_ev(K_RD, 14'h0000, 16'h0000);
    acc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(3);

    chk("sb_drain", 16'(q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
